id_ex_stage_reg: RTL and testbench

//  ID/EX pipeline register, directly downstream of the opcode decoder (ControlUnit).

---
 rtl/id_ex_stage_reg.sv | 137 +++++++++++++
 tb/tb_id_ex_stage_reg.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, hold and flush; 1-cycle latency.
// hold freezes EX and stalls PC/IF-ID; optional bubble counter under `ID_EX_BUBBLE_CNT_EN.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegDst,
  input  logic              ALUSrc,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              Branch,
  input  logic              Jump,
  input  logic              SignZero,
  input  logic [1:0]        ALUOp,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              hold,
  input  logic              flush,
  output logic              ex_RegDst,
  output logic              ex_ALUSrc,
  output logic              ex_MemtoReg,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_Branch,
  output logic              ex_Jump,
  output logic              ex_SignZero,
  output logic [1:0]        ex_ALUOp,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_valid,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic       RegDst;
    logic       ALUSrc;
    logic       MemtoReg;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       Branch;
    logic       Jump;
    logic       SignZero;
    logic [1:0] ALUOp;
  } ctrl_t;

  ctrl_t idCtrl;
  ctrl_t exCtrl;
  logic  luHaz;
  logic  loadData;
  logic  bubbleWr;

  assign idCtrl = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                   Branch, Jump, SignZero, ALUOp};

  assign luHaz = ex_valid & exCtrl.MemRead & (ex_rt != '0) &
                 ((ex_rt == id_rs) | (ex_rt == id_rt));

  // flush outranks hold: a squashed instruction must never linger in EX.
  assign loadData = flush | ~hold;
  assign bubbleWr = flush | (~hold & luHaz);

  assign PCWrite   = ~(hold | (luHaz & ~flush));
  assign IFIDWrite = PCWrite;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exCtrl   <= '0;
      ex_valid <= 1'b0;
      ex_pc4   <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
    end else if (loadData) begin
      exCtrl   <= bubbleWr ? '0 : idCtrl;
      ex_valid <= ~bubbleWr;
      ex_pc4   <= id_pc4;
      ex_rd1   <= id_rd1;
      ex_rd2   <= id_rd2;
      ex_imm   <= id_imm;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
    end
  end

  assign ex_RegDst   = exCtrl.RegDst;
  assign ex_ALUSrc   = exCtrl.ALUSrc;
  assign ex_MemtoReg = exCtrl.MemtoReg;
  assign ex_RegWrite = exCtrl.RegWrite;
  assign ex_MemRead  = exCtrl.MemRead;
  assign ex_MemWrite = exCtrl.MemWrite;
  assign ex_Branch   = exCtrl.Branch;
  assign ex_Jump     = exCtrl.Jump;
  assign ex_SignZero = exCtrl.SignZero;
  assign ex_ALUOp    = exCtrl.ALUOp;

`ifdef ID_EX_BUBBLE_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  logic [CNT_W-1:0] bubbleCnt;

  // Saturating so a long-running counter never wraps back to a small value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubbleCnt <= '0;
    end else if (bubbleWr && (bubbleCnt != '1)) begin
      bubbleCnt <= bubbleCnt + CNT_ONE;
    end
  end

  assign bubble_cnt = bubbleCnt;
`else
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: hand-derived vector table, reset-mid-stall sequence, random run
// against a transaction-level model of the EX slot; counter saturation when ID_EX_BUBBLE_CNT_EN is set.
module tb_id_ex_stage_reg;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 16;

  // ctl bit order: RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite Branch Jump SignZero ALUOp[1:0]
  localparam logic [10:0] C_RTYPE = 11'b10010000010;
  localparam logic [10:0] C_LW    = 11'b01111000000;
  localparam logic [10:0] C_SW    = 11'b01000100000;
  localparam logic [10:0] C_BEQ   = 11'b00000010001;
  localparam logic [10:0] C_ADDI  = 11'b01010000000;

  typedef struct packed {
    logic [10:0]   ctl;
    logic [DW-1:0] pc4, rd1, rd2, imm;
    logic [RW-1:0] rs, rt, rd;
  } id_t;

  typedef struct packed {
    id_t  f;
    logic vld;
  } ex_t;

  typedef struct {
    logic [10:0] ctl;
    logic [4:0]  rs, rt;
    logic [31:0] imm;
    logic        hold, flush;
    logic        expPc;
    logic        expVld;
    logic [10:0] expCtl;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  id_t  inp;
  logic hold, flush;

  logic          ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead;
  logic          ex_MemWrite, ex_Branch, ex_Jump, ex_SignZero;
  logic [1:0]    ex_ALUOp;
  logic [DW-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [RW-1:0] ex_rs, ex_rt, ex_rd;
  logic          ex_valid, PCWrite, IFIDWrite;
  logic [CW-1:0] bubble_cnt;

  ex_t  act;
  ex_t  m;
  int   cnt;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[22];

  always #5 clk = ~clk;

  assign act = {ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite,
                ex_Branch, ex_Jump, ex_SignZero, ex_ALUOp,
                ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_valid};

  id_ex_stage_reg #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .RegDst(inp.ctl[10]), .ALUSrc(inp.ctl[9]), .MemtoReg(inp.ctl[8]), .RegWrite(inp.ctl[7]),
    .MemRead(inp.ctl[6]), .MemWrite(inp.ctl[5]), .Branch(inp.ctl[4]), .Jump(inp.ctl[3]),
    .SignZero(inp.ctl[2]), .ALUOp(inp.ctl[1:0]),
    .id_pc4(inp.pc4), .id_rd1(inp.rd1), .id_rd2(inp.rd2), .id_imm(inp.imm),
    .id_rs(inp.rs), .id_rt(inp.rt), .id_rd(inp.rd),
    .hold(hold), .flush(flush),
    .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_Branch(ex_Branch), .ex_Jump(ex_Jump), .ex_SignZero(ex_SignZero), .ex_ALUOp(ex_ALUOp),
    .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string nm, input logic [199:0] a, input logic [199:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
    end
  endtask

  function automatic int expCnt();
`ifdef ID_EX_BUBBLE_CNT_EN
    return cnt;
`else
    return 0;
`endif
  endfunction

  function automatic void addBubble();
    if (cnt < 65535) cnt++;
  endfunction

  task automatic randData();
    inp.pc4 = $urandom;
    inp.rd1 = $urandom;
    inp.rd2 = $urandom;
    inp.imm = $urandom;
    inp.rd  = 5'($urandom);
  endtask

  // One ID->EX transfer: stall outputs checked before the edge, EX contents after it.
  task automatic step(input string tag);
    bit haz;
    bit expPc;
    haz   = m.vld && m.f.ctl[6] && (m.f.rt != 0) && ((m.f.rt == inp.rs) || (m.f.rt == inp.rt));
    expPc = !(hold || (haz && !flush));
    #1;
    chk({tag, "_PCWrite"}, 200'(PCWrite), 200'(expPc));
    chk({tag, "_IFIDWrite"}, 200'(IFIDWrite), 200'(expPc));
    @(posedge clk);
    if (flush) begin
      m.f = inp; m.f.ctl = '0; m.vld = 1'b0; addBubble();
    end else if (!hold) begin
      m.f = inp;
      if (haz) begin
        m.f.ctl = '0; m.vld = 1'b0; addBubble();
      end else begin
        m.vld = 1'b1;
      end
    end
    #1;
    chk({tag, "_ex"}, 200'(act), 200'(m));
    chk({tag, "_cnt"}, 200'(bubble_cnt), 200'(expCnt()));
  endtask

  initial begin
    //          ctl      rs  rt  imm    hold flush pc  vld expCtl
    tbl[0]  = '{C_RTYPE, 1,  2,  32'h0, 0, 0, 1, 1, C_RTYPE};
    tbl[1]  = '{C_LW,    1,  5,  32'h4, 0, 0, 1, 1, C_LW};
    tbl[2]  = '{C_RTYPE, 5,  6,  32'h0, 0, 0, 0, 0, 11'h0};
    tbl[3]  = '{C_RTYPE, 5,  6,  32'h0, 0, 0, 1, 1, C_RTYPE};
    tbl[4]  = '{C_LW,    0,  0,  32'h0, 0, 0, 1, 1, C_LW};
    tbl[5]  = '{C_RTYPE, 0,  7,  32'h0, 0, 0, 1, 1, C_RTYPE};
    tbl[6]  = '{C_LW,    1,  8,  32'h0, 0, 0, 1, 1, C_LW};
    tbl[7]  = '{C_LW,    8,  9,  32'h0, 0, 0, 0, 0, 11'h0};
    tbl[8]  = '{C_LW,    8,  9,  32'h0, 0, 0, 1, 1, C_LW};
    tbl[9]  = '{C_SW,    1,  9,  32'h0, 0, 0, 0, 0, 11'h0};
    tbl[10] = '{C_SW,    1,  9,  32'h0, 0, 0, 1, 1, C_SW};
    tbl[11] = '{C_LW,    1,  10, 32'h0, 0, 0, 1, 1, C_LW};
    tbl[12] = '{C_BEQ,   10, 11, 32'h0, 0, 1, 1, 0, 11'h0};
    tbl[13] = '{C_ADDI,  1,  12, 32'h8, 0, 0, 1, 1, C_ADDI};
    tbl[14] = '{C_RTYPE, 2,  3,  32'h0, 1, 0, 0, 1, C_ADDI};
    tbl[15] = '{C_RTYPE, 2,  3,  32'h0, 1, 0, 0, 1, C_ADDI};
    tbl[16] = '{C_RTYPE, 2,  3,  32'h0, 1, 0, 0, 1, C_ADDI};
    tbl[17] = '{C_RTYPE, 2,  3,  32'h0, 0, 0, 1, 1, C_RTYPE};
    tbl[18] = '{C_LW,    1,  13, 32'h0, 0, 0, 1, 1, C_LW};
    tbl[19] = '{C_RTYPE, 13, 4,  32'h0, 1, 0, 0, 1, C_LW};
    tbl[20] = '{C_RTYPE, 13, 4,  32'h0, 0, 0, 0, 0, 11'h0};
    tbl[21] = '{C_RTYPE, 13, 4,  32'h0, 0, 0, 1, 1, C_RTYPE};

    // Reset asserted with random ID-side inputs.
    reset = 1'b1; hold = 1'b0; flush = 1'b0;
    inp = id_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
    #3;
    chk("reset_ex", 200'(act), 200'(0));
    chk("reset_cnt", 200'(bubble_cnt), 200'(0));
    chk("reset_PCWrite", 200'(PCWrite), 200'(1));
    m = '0; cnt = 0;
    #9 reset = 1'b0;

    foreach (tbl[i]) begin
      inp.ctl = tbl[i].ctl; inp.rs = tbl[i].rs; inp.rt = tbl[i].rt;
      randData();
      if (tbl[i].ctl == C_ADDI) inp.imm = tbl[i].imm;
      hold = tbl[i].hold; flush = tbl[i].flush;
      #1;
      chk($sformatf("tbl%0d_pc", i), 200'(PCWrite), 200'(tbl[i].expPc));
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_vld", i), 200'(ex_valid), 200'(tbl[i].expVld));
      chk($sformatf("tbl%0d_ctl", i), 200'(act.f.ctl), 200'(tbl[i].expCtl));
      if (i >= 13 && i <= 16)
        chk($sformatf("tbl%0d_imm", i), 200'(ex_imm), 200'(32'h8));
    end

    // Reset during a live load-use stall drops the stall immediately.
    inp.ctl = C_LW; inp.rs = 1; inp.rt = 3; randData(); hold = 0; flush = 0;
    step("ms_load");
    inp.ctl = C_RTYPE; inp.rs = 3; inp.rt = 4; randData();
    #1;
    chk("ms_stall_PCWrite", 200'(PCWrite), 200'(0));
    reset = 1'b1;
    #1;
    chk("ms_reset_PCWrite", 200'(PCWrite), 200'(1));
    chk("ms_reset_ex", 200'(act), 200'(0));
    chk("ms_reset_cnt", 200'(bubble_cnt), 200'(0));
    m = '0; cnt = 0;
    @(negedge clk) reset = 1'b0;

    for (int k = 0; k < 400; k++) begin
      inp.ctl = 11'($urandom);
      inp.rs  = 5'($urandom_range(0, 3));
      inp.rt  = 5'($urandom_range(0, 3));
      randData();
      hold  = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 6) == 0);
      step($sformatf("rnd%0d", k));
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    flush = 1'b1; hold = 1'b0;
    for (int k = 0; k < 65540; k++) begin
      randData();
      step("sat");
    end
    chk("sat_cnt", 200'(bubble_cnt), 200'(16'hFFFF));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
